shifter_op_sequencer: RTL and testbench

Sequences the barrel shifter for ARM data-processing operand2. Accepts a decoded instruction from issue and fetches Rm/Rs through one shared register-file read port. Drives the shifter control lines, captures the result and shifter carry-out, and hands operand2 to the ALU stage over a valid/ready handshake. Register-specified shifts take an extra read cycle, matching ARM multi-cycle behaviour.

---
 rtl/shifter_op_sequencer_pkg.sv | 39 +++
 rtl/shifter_op_sequencer.sv | 138 +++++++++++++
 tb/tb_shifter_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_op_sequencer_pkg.sv
// Shared definitions for the operand2 shifter sequencer: FSM states, shift
// type codes, data-processing instruction field positions and fast-path tests.
package shifter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_RM,
    RD_RS,
    SHIFT,
    CAPT,
    DONE
  } state_t;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  localparam int unsigned I_BIT     = 25;
  localparam int unsigned RM_LSB    = 0;   // Rm   = [3:0]
  localparam int unsigned RS_LSB    = 8;   // Rs   = [11:8]
  localparam int unsigned AMT_LSB   = 7;   // amt  = [11:7]
  localparam int unsigned TYPE_LSB  = 5;   // type = [6:5]
  localparam int unsigned REGSH_BIT = 4;
  localparam int unsigned ROT_LSB   = 8;   // rot  = [11:8]
  localparam int unsigned IMM_LSB   = 0;   // imm  = [7:0]

  // Immediate with no rotation: operand2 is just the zero-extended byte.
  function automatic logic is_fast_imm(input logic [31:0] instr);
    return instr[I_BIT] && (instr[ROT_LSB +: 4] == 4'd0);
  endfunction

  // Register operand with LSL #0: operand2 is Rm unchanged.
  function automatic logic is_fast_rm(input logic [31:0] instr);
    return !instr[I_BIT] && !instr[REGSH_BIT] &&
           (instr[TYPE_LSB +: 2] == LSL) && (instr[AMT_LSB +: 5] == 5'd0);
  endfunction

endpackage

// File: rtl/shifter_op_sequencer.sv
// Operand2 sequencer: fetches Rm/Rs over one RF read port, drives the barrel
// shifter and hands the result to the ALU. Optional fast path: SHOP_FASTPATH_EN.
module shifter_op_sequencer
  import shifter_pkg::*;
#(
  parameter int RF_AW = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             cpsr_c,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [DW-1:0]    rf_rdata,
  output logic             sh_enable,
  output logic [DW-1:0]    sh_in_data,
  output logic [7:0]       sh_in_data_imm,
  output logic             sh_imm_or_reg,
  output logic [2:0]       sh_shift_control,
  output logic [4:0]       sh_shift_amt_imm,
  output logic [DW-1:0]    sh_shift_amt_reg,
  output logic [3:0]       sh_rotation_code,
  output logic             sh_carry_in,
  input  logic [DW-1:0]    sh_out_data,
  input  logic             sh_carry_out,
  output logic             op2_valid,
  input  logic             op2_ready,
  output logic [DW-1:0]    op2_data,
  output logic             op2_carry
);

`ifdef SHOP_FASTPATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  state_t        state;
  logic [31:0]   instr_q;
  logic          c_q;
  logic [DW-1:0] rm_q;
  logic [DW-1:0] rs_q;
  logic          unused_instr_bits;

  assign unused_instr_bits = ^{instr_q[31:26], instr_q[24:12]};

  // Shifter controls come straight from the holding registers, so they are
  // stable from SHIFT through CAPT without extra output flops.
  assign sh_in_data       = rm_q;
  assign sh_in_data_imm   = instr_q[IMM_LSB +: 8];
  assign sh_imm_or_reg    = instr_q[I_BIT];
  assign sh_shift_control = {instr_q[REGSH_BIT], instr_q[TYPE_LSB +: 2]};
  assign sh_shift_amt_imm = instr_q[AMT_LSB +: 5];
  assign sh_shift_amt_reg = rs_q;
  assign sh_rotation_code = instr_q[ROT_LSB +: 4];
  assign sh_carry_in      = c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      op2_valid <= 1'b0;
      sh_enable <= 1'b0;
      op2_data  <= '0;
      op2_carry <= 1'b0;
      rf_raddr  <= '0;
      instr_q   <= '0;
      c_q       <= 1'b0;
      rm_q      <= '0;
      rs_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            instr_q  <= in_instr;
            c_q      <= cpsr_c;
            in_ready <= 1'b0;
            if (in_instr[I_BIT]) begin
              if (FAST_EN && is_fast_imm(in_instr)) begin
                op2_data  <= DW'(in_instr[IMM_LSB +: 8]);
                op2_carry <= cpsr_c;
                op2_valid <= 1'b1;
                state     <= DONE;
              end else begin
                sh_enable <= 1'b1;
                state     <= SHIFT;
              end
            end else begin
              rf_raddr <= RF_AW'(in_instr[RM_LSB +: 4]);
              state    <= RD_RM;
            end
          end
        end
        RD_RM: begin
          rm_q <= rf_rdata;
          if (instr_q[REGSH_BIT]) begin
            rf_raddr <= RF_AW'(instr_q[RS_LSB +: 4]);
            state    <= RD_RS;
          end else if (FAST_EN && is_fast_rm(instr_q)) begin
            op2_data  <= rf_rdata;
            op2_carry <= c_q;
            op2_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sh_enable <= 1'b1;
            state     <= SHIFT;
          end
        end
        RD_RS: begin
          rs_q      <= rf_rdata;
          sh_enable <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          sh_enable <= 1'b0;
          state     <= CAPT;
        end
        CAPT: begin
          op2_data  <= sh_out_data;
          op2_carry <= sh_carry_out;
          op2_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (op2_ready) begin
            op2_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_op_sequencer.sv
// Self-checking bench for shifter_op_sequencer: behavioural register file and
// barrel shifter, table-driven instructions, scoreboard on the op2 handshake.
module tb_shifter_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cpsr_c;
  logic [31:0] in_instr;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        sh_enable, sh_imm_or_reg, sh_carry_in, sh_carry_out;
  logic [31:0] sh_in_data, sh_shift_amt_reg, sh_out_data;
  logic [7:0]  sh_in_data_imm;
  logic [2:0]  sh_shift_control;
  logic [4:0]  sh_shift_amt_imm;
  logic [3:0]  sh_rotation_code;
  logic        op2_valid, op2_ready, op2_carry;
  logic [31:0] op2_data;

  shifter_op_sequencer #(.RF_AW(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .cpsr_c(cpsr_c), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .sh_enable(sh_enable), .sh_in_data(sh_in_data), .sh_in_data_imm(sh_in_data_imm),
    .sh_imm_or_reg(sh_imm_or_reg), .sh_shift_control(sh_shift_control),
    .sh_shift_amt_imm(sh_shift_amt_imm), .sh_shift_amt_reg(sh_shift_amt_reg),
    .sh_rotation_code(sh_rotation_code), .sh_carry_in(sh_carry_in),
    .sh_out_data(sh_out_data), .sh_carry_out(sh_carry_out),
    .op2_valid(op2_valid), .op2_ready(op2_ready), .op2_data(op2_data), .op2_carry(op2_carry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [16];
  assign rf_rdata = regs[rf_raddr];

  function automatic logic [32:0] do_shift(input logic [31:0] v, input logic [1:0] t,
                                           input int unsigned amt, input logic cin);
    logic [31:0] r;
    logic        c;
    if (amt == 0) return {cin, v};
    case (t)
      2'b00:   begin r = v << amt; c = v[32-amt]; end
      2'b01:   begin r = v >> amt; c = v[amt-1]; end
      2'b10:   begin r = 32'($signed(v) >>> amt); c = v[amt-1]; end
      default: begin r = (v >> amt) | (v << (32-amt)); c = v[amt-1]; end
    endcase
    return {c, r};
  endfunction

  // Behavioural shifter driven only by the DUT's sh_* controls.
  always_comb begin
    int unsigned amt;
    amt = 0;
    if (sh_imm_or_reg) begin
      {sh_carry_out, sh_out_data} = do_shift({24'd0, sh_in_data_imm}, 2'b11,
                                             2 * int'(sh_rotation_code), sh_carry_in);
    end else begin
      amt = sh_shift_control[2] ? int'(sh_shift_amt_reg[7:0]) : int'(sh_shift_amt_imm);
      {sh_carry_out, sh_out_data} = do_shift(sh_in_data, sh_shift_control[1:0], amt, sh_carry_in);
    end
  end

  // Reference operand2 computed from the instruction word and register array.
  function automatic logic [32:0] ref_op2(input logic [31:0] instr, input logic c);
    int unsigned amt;
    if (instr[25]) return do_shift({24'd0, instr[7:0]}, 2'b11, 2 * int'(instr[11:8]), c);
    amt = instr[4] ? int'(regs[instr[11:8]][7:0]) : int'(instr[11:7]);
    return do_shift(regs[instr[3:0]], instr[6:5], amt, c);
  endfunction

  function automatic logic [31:0] mk_imm(input int unsigned rot, input int unsigned imm);
    return 32'(1 << 25) | 32'(rot << 8) | 32'(imm);
  endfunction
  function automatic logic [31:0] mk_rimm(input int unsigned rm, input int unsigned t, input int unsigned amt);
    return 32'(amt << 7) | 32'(t << 5) | 32'(rm);
  endfunction
  function automatic logic [31:0] mk_rreg(input int unsigned rm, input int unsigned t, input int unsigned rs);
    return 32'(rs << 8) | 32'(t << 5) | 32'(1 << 4) | 32'(rm);
  endfunction

  function automatic int exp_latency(input logic [31:0] instr, input int normal);
`ifdef SHOP_FASTPATH_EN
    if (instr[25] && instr[11:8] == 4'd0) return 1;
    if (!instr[25] && !instr[4] && instr[6:5] == 2'b00 && instr[11:7] == 5'd0) return 2;
`endif
    return normal;
  endfunction

  // Scoreboard: pushed on accept, popped on the op2 handshake.
  logic [32:0] exp_q [$];

  always @(negedge clk) begin
    if (rst_n && op2_valid && op2_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h carry=%b", op2_data, op2_carry);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({op2_carry, op2_data} !== e) begin
          errors++;
          $display("FAIL sb_op2 got carry=%b data=%h exp carry=%b data=%h",
                   op2_carry, op2_data, e[32], e[31:0]);
        end
      end
    end
  end

  int          pulses;
  logic [31:0] cap_in_data, cap_amt_reg;
  logic [4:0]  cap_amt_imm;
  always @(negedge clk) begin
    if (sh_enable) begin
      pulses++;
      cap_in_data = sh_in_data;
      cap_amt_imm = sh_shift_amt_imm;
      cap_amt_reg = sh_shift_amt_reg;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        c;
    int          delay;
    int          lat;
  } vec_t;

  vec_t        vecs [9];
  logic [3:0]  raddr_log [8];

  task automatic run_vec(input vec_t v, output int lat);
    int          n;
    int          exp_lat;
    logic [32:0] first;
    logic        stable;
    exp_lat = exp_latency(v.instr, v.lat);
    in_instr = v.instr;
    cpsr_c   = v.c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 exp 1");
    end
    exp_q.push_back(ref_op2(v.instr, v.c));
    pulses = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    raddr_log[1] = rf_raddr;
    while (!op2_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 8) raddr_log[lat] = rf_raddr;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    first  = {op2_carry, op2_data};
    stable = 1'b1;
    for (int k = 0; k < v.delay; k++) begin
      if ({op2_carry, op2_data} !== first || in_ready !== 1'b0 || op2_valid !== 1'b1) stable = 1'b0;
      @(posedge clk); #1;
    end
    if (v.delay > 0) check("backpressure_stable", 32'(stable), 32'd1);
    op2_ready = 1'b1;
    @(posedge clk); #1;
    op2_ready = 1'b0;
    check("post_hs_valid", 32'(op2_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("sh_enable_pulses", 32'(pulses), (exp_lat == v.lat) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int lat;
    for (int r = 0; r < 16; r++) regs[r] = 32'(r) * 32'h01010101;
    regs[0]  = 32'd0;
    regs[1]  = 32'h80000009;
    regs[2]  = 32'h80000009;
    regs[3]  = 32'd2;
    regs[4]  = 32'hF00000F0;
    regs[5]  = 32'd31;
    regs[6]  = 32'h12345678;
    regs[15] = 32'hCAFE0008;

    vecs[0] = '{mk_imm(1, 8'hB8),   1'b0, 0, 3};
    vecs[1] = '{mk_rimm(2, 1, 4),   1'b0, 1, 4};
    vecs[2] = '{mk_rreg(1, 3, 3),   1'b1, 0, 5};
    vecs[3] = '{mk_imm(0, 8'h5A),   1'b1, 0, 3};
    vecs[4] = '{mk_rimm(6, 0, 0),   1'b1, 0, 4};
    vecs[5] = '{mk_rimm(4, 2, 3),   1'b0, 2, 4};
    vecs[6] = '{mk_rreg(6, 0, 5),   1'b0, 0, 5};
    vecs[7] = '{mk_imm(15, 8'hFF),  1'b0, 5, 3};
    vecs[8] = '{mk_rreg(15, 1, 0),  1'b1, 3, 5};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; cpsr_c = 1'b0; op2_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op2_valid", 32'(op2_valid), 32'd0);
    check("rst_op2_data", op2_data, 32'd0);
    check("rst_sh_enable", 32'(sh_enable), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // op2_ready alone in IDLE must not produce anything
    op2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    op2_ready = 1'b0;
    check("idle_ready_no_valid", 32'(op2_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], lat);
      if (i == 1) begin
        check("v1_sh_in_data", cap_in_data, 32'h80000009);
        check("v1_amt_imm", 32'(cap_amt_imm), 32'd4);
      end
      if (i == 2) begin
        check("v2_raddr_rm", 32'(raddr_log[1]), 32'd1);
        check("v2_raddr_rs", 32'(raddr_log[2]), 32'd3);
        check("v2_amt_reg", cap_amt_reg, 32'd2);
      end
      @(posedge clk); #1;
    end

    // Reset while in RD_RS: everything returns to reset values at once
    in_instr = mk_rreg(1, 3, 3);
    cpsr_c   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_raddr_rs", 32'(rf_raddr), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_raddr", 32'(rf_raddr), 32'd0);
    check("midrst_sh_in_data", sh_in_data, 32'd0);
    check("midrst_op2_valid", 32'(op2_valid), 32'd0);
    check("midrst_sh_ctrl", 32'({sh_imm_or_reg, sh_shift_control, sh_carry_in}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[2], lat);
    run_vec(vecs[0], lat);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
